riscv_mem_arbiter: RTL

- Sequences all memory traffic of riscv_core through one single-port memory.
- Arbitrates between the instruction-fetch (IF) port and the load/store (LS) port.
- Allows one outstanding transaction at a time. Issues it on a valid/ready request channel and returns the response to the owner.
- Sits between the core pipeline and the unified instruction/data memory.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/riscv_arb_pick.sv | 36 +++
 rtl/riscv_mem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: FSM state and owner encodings plus default widths shared by the
// riscv_mem_arbiter slice.
package riscv_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/riscv_arb_pick.sv
// riscv_arb_pick: IF/LS grant selector. Fixed LS priority with an IF starvation
// guard by default; round-robin when RISCV_MEM_ARB_RR_EN is defined.
module riscv_arb_pick
   import riscv_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_if_req,
   input  logic i_if_pend,
   input  logic i_ls_req,
   output logic o_gnt_if,
   output logic o_gnt_ls
);
   logic w_pick_if;
`ifdef RISCV_MEM_ARB_RR_EN
   logic r_last;
   assign w_pick_if = i_if_req & (~i_ls_req | (r_last == OWN_LS));
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_last <= OWN_IF;
      else if (o_gnt_if) r_last <= OWN_IF;
      else if (o_gnt_ls) r_last <= OWN_LS;
`else
   logic [3:0] r_cnt;
   assign w_pick_if = i_if_req & (~i_ls_req | (r_cnt >= 4'(STARVE_MAX)));
   // saturate so a long flush-blocked stretch cannot wrap the guard back to zero
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_cnt <= 4'd0;
      else if (o_gnt_if | ~i_if_pend) r_cnt <= 4'd0;
      else if (o_gnt_ls && r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
`endif
   assign o_gnt_if = i_en & w_pick_if;
   assign o_gnt_ls = i_en & i_ls_req & ~w_pick_if;
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: single-outstanding arbiter of IF and LS traffic onto one
// memory port. Define RISCV_MEM_ARB_RR_EN for round-robin instead of fixed priority.
module riscv_mem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_req_addr,
   input  logic                if_flush,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rsp_data,
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic [ADDR_W-1:0]   ls_req_addr,
   input  logic                ls_req_we,
   input  logic [DATA_W-1:0]   ls_req_wdata,
   input  logic [DATA_W/8-1:0] ls_req_be,
   output logic                ls_rsp_valid,
   output logic [DATA_W-1:0]   ls_rsp_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_data
);
   logic [1:0]          r_state;
   logic                r_owner;
   logic                r_flush_pend;
   logic                r_mem_req_valid;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_we;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W/8-1:0] r_mem_be;
   logic                r_if_rsp_valid;
   logic [DATA_W-1:0]   r_if_rsp_data;
   logic                r_ls_rsp_valid;
   logic [DATA_W-1:0]   r_ls_rsp_data;
   logic                w_idle;
   logic                w_gnt_if;
   logic                w_gnt_ls;
   logic                w_flush_hit;
   // readies are combinational from IDLE, so gate with reset to keep them low during reset
   assign w_idle      = rst & (r_state == ST_IDLE);
   assign w_flush_hit = if_flush & (r_owner == OWN_IF) & (r_state != ST_IDLE);
   riscv_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .clk       (clk),
      .rst       (rst),
      .i_en      (w_idle),
      .i_if_req  (if_req_valid & ~if_flush),
      .i_if_pend (if_req_valid),
      .i_ls_req  (ls_req_valid),
      .o_gnt_if  (w_gnt_if),
      .o_gnt_ls  (w_gnt_ls)
   );
   assign if_req_ready  = w_gnt_if;
   assign ls_req_ready  = w_gnt_ls;
   assign mem_req_valid = r_mem_req_valid;
   assign mem_addr      = r_mem_addr;
   assign mem_we        = r_mem_we;
   assign mem_wdata     = r_mem_wdata;
   assign mem_be        = r_mem_be;
   assign if_rsp_valid  = r_if_rsp_valid;
   assign if_rsp_data   = r_if_rsp_data;
   assign ls_rsp_valid  = r_ls_rsp_valid;
   assign ls_rsp_data   = r_ls_rsp_data;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state         <= ST_IDLE;
         r_owner         <= OWN_IF;
         r_flush_pend    <= 1'b0;
         r_mem_req_valid <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_we        <= 1'b0;
         r_mem_wdata     <= '0;
         r_mem_be        <= '0;
         r_if_rsp_valid  <= 1'b0;
         r_if_rsp_data   <= '0;
         r_ls_rsp_valid  <= 1'b0;
         r_ls_rsp_data   <= '0;
      end else begin
         r_if_rsp_valid <= 1'b0;
         r_ls_rsp_valid <= 1'b0;
         if (w_flush_hit) r_flush_pend <= 1'b1;
         if (r_state == ST_IDLE) begin
            if (w_gnt_if | w_gnt_ls) begin
               r_state         <= ST_ISSUE;
               r_mem_req_valid <= 1'b1;
               r_owner         <= w_gnt_ls ? OWN_LS : OWN_IF;
               r_mem_addr      <= w_gnt_ls ? ls_req_addr : if_req_addr;
               r_mem_we        <= w_gnt_ls & ls_req_we;
               r_mem_wdata     <= w_gnt_ls ? ls_req_wdata : '0;
               r_mem_be        <= w_gnt_ls ? ls_req_be : '1;
            end
         end else if (r_state == ST_ISSUE) begin
            if (mem_req_ready) begin
               r_state         <= ST_WAIT;
               r_mem_req_valid <= 1'b0;
            end
         end else if (mem_rsp_valid) begin
            r_state      <= ST_IDLE;
            r_flush_pend <= 1'b0;
            if (r_owner == OWN_LS) begin
               r_ls_rsp_valid <= 1'b1;
               r_ls_rsp_data  <= mem_rsp_data;
            end else if (!(r_flush_pend | if_flush)) begin
               r_if_rsp_valid <= 1'b1;
               r_if_rsp_data  <= mem_rsp_data;
            end
         end
      end
endmodule
